// File: rtl/cesa_pkg.sv
// Shared types and helpers for the CESA variable-latency adder.
//   BLK_W   : width of one speculative slice
//   state_e : controller states
//   clog2() : index width helper for the slice counter
package cesa_pkg;

  localparam int unsigned BLK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Ceiling log2 for elaboration-time widths
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/block4.sv
// Speculative 4-bit slice.
// The carry-out is predicted from the slice operands alone (carry-in taken as 0),
// so no carry chain crosses slice boundaries in the speculative path.
//   i_a, i_b       : slice operands
//   i_cin          : speculative carry-in from the slice below
//   o_sum_c        : slice sum using i_cin
//   o_spec_cout_c  : predicted carry-out (generate of i_a+i_b)
module block4
  import cesa_pkg::*;
(
  input  logic [BLK_W-1:0] i_a,
  input  logic [BLK_W-1:0] i_b,
  input  logic             i_cin,
  output logic [BLK_W-1:0] o_sum_c,
  output logic             o_spec_cout_c
);

  localparam int unsigned SUM_W = BLK_W + 1;

  logic [BLK_W-1:0] w_gen_unused;

  assign o_sum_c = i_a + i_b + BLK_W'(i_cin);
  assign {o_spec_cout_c, w_gen_unused} = SUM_W'(i_a) + SUM_W'(i_b);

endmodule

// File: rtl/cesa_blk_fix.sv
// Exact 4-bit slice adder with a carry-prediction mismatch flag.
//   i_a, i_b      : slice operands
//   i_cin         : carry-in used for the exact addition
//   i_spec_cout   : carry-out predicted for this slice
//   o_sum_c       : exact slice sum
//   o_cout_c      : exact slice carry-out
//   o_mis_c       : exact carry-out differs from the prediction
module cesa_blk_fix
  import cesa_pkg::*;
(
  input  logic [BLK_W-1:0] i_a,
  input  logic [BLK_W-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_spec_cout,
  output logic [BLK_W-1:0] o_sum_c,
  output logic             o_cout_c,
  output logic             o_mis_c
);

  localparam int unsigned SUM_W = BLK_W + 1;

  assign {o_cout_c, o_sum_c} = SUM_W'(i_a) + SUM_W'(i_b) + SUM_W'(i_cin);
  assign o_mis_c             = o_cout_c ^ i_spec_cout;

endmodule

// File: rtl/cesa_spec_fix.sv
// Variable-latency WIDTH-bit adder: speculative sum in one cycle, then serial
// repair of slices from the first carry misprediction up to the top slice.
// Optional feature macro: CESA_ERR_CNT_EN adds err_cnt_o, a saturating count
// of delivered results that needed correction.
//   clk_i, rst_ni            : clock, async active-low reset
//   in_valid_i / in_ready_o  : operand handshake (ready only when idle)
//   a_i, b_i, cin_i          : operands
//   out_valid_o / out_ready_i: result handshake
//   sum_o, cout_o            : exact sum and carry-out
//   spec_err_o               : result went through the repair path
//   err_cnt_o                : (CESA_ERR_CNT_EN only) corrected-result count
module cesa_spec_fix
  import cesa_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             spec_err_o
`ifdef CESA_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt_o
`endif
);

  localparam int unsigned NBLK  = WIDTH / BLK_W;
  localparam int unsigned IDX_W = (NBLK > 1) ? clog2(NBLK) : 1;

  typedef logic [NBLK-1:0][BLK_W-1:0] slices_t;

  state_e           r_state,     w_state_nxt;
  slices_t          r_a,         w_a_nxt;
  slices_t          r_b,         w_b_nxt;
  slices_t          r_sum,       w_sum_nxt;
  logic             r_cin,       w_cin_nxt;
  logic             r_carry,     w_carry_nxt;
  logic             r_cout,      w_cout_nxt;
  logic             r_spec_err,  w_spec_err_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [IDX_W-1:0] r_idx,       w_idx_nxt;

  // Speculative carries: w_cspec[k] is the carry-in assumed for slice k
  logic [NBLK:0]    w_cspec;
  slices_t          w_ssum;
  slices_t          w_xsum;
  logic [NBLK-1:0]  w_xcout;
  logic [NBLK-1:0]  w_mis;
  logic             w_err_any;
  logic [IDX_W-1:0] w_kf;
  logic [BLK_W-1:0] w_fsum;
  logic             w_fcout;
  logic             w_fmis;
  logic             w_unused;

  assign w_cspec[0] = r_cin;

  // Per-slice speculation plus exact check; w_mis[k] flags slice k+1 as wrong
  for (genvar k = 0; k < NBLK; k++) begin : g_slice
    block4 u_spec (
      .i_a           (r_a[k]),
      .i_b           (r_b[k]),
      .i_cin         (w_cspec[k]),
      .o_sum_c       (w_ssum[k]),
      .o_spec_cout_c (w_cspec[k+1])
    );

    cesa_blk_fix u_chk (
      .i_a         (r_a[k]),
      .i_b         (r_b[k]),
      .i_cin       (w_cspec[k]),
      .i_spec_cout (w_cspec[k+1]),
      .o_sum_c     (w_xsum[k]),
      .o_cout_c    (w_xcout[k]),
      .o_mis_c     (w_mis[k])
    );
  end

  // Single repair adder walking up the slices
  cesa_blk_fix u_fix (
    .i_a         (r_a[r_idx]),
    .i_b         (r_b[r_idx]),
    .i_cin       (r_carry),
    .i_spec_cout (1'b0),
    .o_sum_c     (w_fsum),
    .o_cout_c    (w_fcout),
    .o_mis_c     (w_fmis)
  );

  // Top-slice prediction has no consumer; exact check sums equal the speculative ones
  assign w_unused = ^{w_xsum, w_mis[NBLK-1], w_cspec[NBLK], w_fmis};

  // Lowest mispredicted slice index
  always_comb begin
    w_err_any = |w_mis[NBLK-2:0];
    w_kf      = '0;
    for (int k = int'(NBLK) - 2; k >= 0; k--) begin
      if (w_mis[k]) w_kf = IDX_W'(k + 1);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_cin_nxt       = r_cin;
    w_sum_nxt       = r_sum;
    w_carry_nxt     = r_carry;
    w_cout_nxt      = r_cout;
    w_spec_err_nxt  = r_spec_err;
    w_idx_nxt       = r_idx;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      IDLE: begin
        if (in_valid_i) begin
          w_a_nxt     = a_i;
          w_b_nxt     = b_i;
          w_cin_nxt   = cin_i;
          w_state_nxt = CHK;
        end
      end
      CHK: begin
        if (!w_err_any) begin
          w_sum_nxt      = w_ssum;
          w_cout_nxt     = w_xcout[NBLK-1];
          w_spec_err_nxt = 1'b0;
          w_state_nxt    = DONE;
        end else begin
          // Slices below the first misprediction saw correct carries
          for (int unsigned k = 0; k < NBLK; k++) begin
            if (IDX_W'(k) < w_kf) w_sum_nxt[k] = w_ssum[k];
          end
          w_carry_nxt    = w_xcout[w_kf - IDX_W'(1)];
          w_idx_nxt      = w_kf;
          w_spec_err_nxt = 1'b1;
          w_state_nxt    = FIX;
        end
      end
      FIX: begin
        w_sum_nxt[r_idx] = w_fsum;
        w_carry_nxt      = w_fcout;
        w_idx_nxt        = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(NBLK - 1)) begin
          w_cout_nxt  = w_fcout;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_out_valid_nxt = (w_state_nxt == DONE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_spec_err  <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_cin       <= w_cin_nxt;
      r_sum       <= w_sum_nxt;
      r_carry     <= w_carry_nxt;
      r_cout      <= w_cout_nxt;
      r_spec_err  <= w_spec_err_nxt;
      r_idx       <= w_idx_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign sum_o       = r_sum;
  assign cout_o      = r_cout;
  assign spec_err_o  = r_spec_err;

`ifdef CESA_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  // Counts corrected results at the output handshake, saturating
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if ((r_state == DONE) && out_ready_i && r_spec_err &&
                 (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_cesa_spec_fix.sv
// Bench for cesa_spec_fix: directed vector table, backpressure and mid-repair
// reset sequences, then random operands checked against a+b+cin and a
// slice-level carry-prediction model for latency.
module tb_cesa_spec_fix;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          spec_err;
`ifdef CESA_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  cesa_spec_fix #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .spec_err_o  (spec_err)
`ifdef CESA_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                              input logic [31:0] s, input logic co, input logic er, input int l);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc;
    v.e.sum = s; v.e.cout = co; v.e.err = er; v.e.lat = l;
    return v;
  endfunction

  // Latency from the slice carry-prediction scheme: predicted carry = generate of a+b
  function automatic int model_lat(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [8:0] cs;
    int ak, bk;
    cs[0] = c;
    for (int k = 0; k < 8; k++) begin
      ak = int'(x[k*4 +: 4]);
      bk = int'(y[k*4 +: 4]);
      cs[k+1] = ((ak + bk) > 15);
    end
    for (int k = 1; k < 8; k++) begin
      ak = int'(x[(k-1)*4 +: 4]);
      bk = int'(y[(k-1)*4 +: 4]);
      if (((ak + bk + int'(cs[k-1])) > 15) != cs[k]) return 1 + (8 - k);
    end
    return 1;
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
    exp_t e;
    logic [32:0] t;
    t      = 33'(x) + 33'(y) + 33'(c);
    e.sum  = t[31:0];
    e.cout = t[32];
    e.lat  = model_lat(x, y, c);
    e.err  = (e.lat != 1);
    return e;
  endfunction

  // One transaction: push expectation, drive, wait for result, pop and compare
  task automatic xact(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                      input exp_t e, input int hold, input string nm);
    int n;
    exp_t q;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tbv; cin = tc; in_valid = 1'b1;
    out_ready = (hold == 0);
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    q = sb_q.pop_front();
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL %s timeout: got no out_valid want latency %0d", nm, q.lat);
      out_ready = 1'b1;
      return;
    end
    chk({nm, " sum"},  sum, q.sum);
    chk({nm, " cout"}, 32'(cout), 32'(q.cout));
    chk({nm, " err"},  32'(spec_err), 32'(q.err));
    chk({nm, " lat"},  32'(n), 32'(q.lat));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({nm, " hold valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold ready"}, 32'(in_ready), 32'd0);
      chk({nm, " hold sum"},   sum, q.sum);
      chk({nm, " hold cout"},  32'(cout), 32'(q.cout));
      chk({nm, " hold err"},   32'(spec_err), 32'(q.err));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " post valid"}, 32'(out_valid), 32'd0);
    chk({nm, " post ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    logic rc;

    vecs[0] = mk(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1);
    vecs[1] = mk(32'h0000000F, 32'h00000000, 1'b1, 32'h00000010, 1'b0, 1'b1, 8);
    vecs[2] = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 7);
    vecs[3] = mk(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
    vecs[4] = mk(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 8);
    vecs[5] = mk(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1);
    vecs[6] = mk(32'h000000F0, 32'h00000010, 1'b0, 32'h00000100, 1'b0, 1'b0, 1);
    vecs[7] = mk(32'h0FFFFFFF, 32'h00000000, 1'b1, 32'h10000000, 1'b0, 1'b1, 8);
    vecs[8] = mk(32'h7FFFFFF8, 32'h00000008, 1'b0, 32'h80000000, 1'b0, 1'b1, 7);
    vecs[9] = mk(32'h0FF00000, 32'h00100000, 1'b0, 32'h10000000, 1'b0, 1'b1, 2);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    #12;
    chk("reset in_ready",  32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum",       sum, 32'd0);
    chk("reset cout",      32'(cout), 32'd0);
    chk("reset err",       32'(spec_err), 32'd0);
`ifdef CESA_ERR_CNT_EN
    chk("reset err_cnt",   32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      xact(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e, 0, $sformatf("vec%0d", i));
`ifdef CESA_ERR_CNT_EN
      if (i == 2) chk("err_cnt after 3", 32'(err_cnt), 32'd2);
`endif
    end

    // Backpressure on a clean result and on a repaired result
    xact(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].e, 5, "bp clean");
    xact(vecs[1].a, vecs[1].b, vecs[1].cin, vecs[1].e, 5, "bp fixed");

    // Reset in the middle of the repair walk
    a = 32'h0000000F; b = 32'h0; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready",  32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst sum",       sum, 32'd0);
    chk("midrst cout",      32'(cout), 32'd0);
    chk("midrst err",       32'(spec_err), 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("midrst no result", 32'(out_valid), 32'd0);
    e = model(32'd5, 32'd5, 1'b0);
    chk("midrst model sum", e.sum, 32'h0000000A);
    xact(32'd5, 32'd5, 1'b0, e, 0, "after rst");

    // Random operands against the reference model
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = ~ra;
      xact(ra, rb, rc, model(ra, rb, rc), (i % 97 == 0) ? 2 : 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
